bram_stream_reader: RTL and testbench
=====================================

Name: bram_stream_reader

Overview:
- Read-side master for the team's negedge-clocked dual-port block RAM: drives its read port (b), fetches a contiguous block of words, and presents them as a valid/ready stream.
- Used by the MLP datapath to stream weights and activations out of on-chip RAM into the MAC pipeline.
- Absorbs the RAM read latency with a 2-entry output buffer, so downstream backpressure never loses or duplicates a word.

Parameters:
- DWIDTH, 16, RAM word width and stream data width.
- LOG_LEN, 8, RAM address width; RAM depth is 2**LOG_LEN.

Ports:
- clk  in  1  system clock; all logic in this block on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
- base_addr  in  LOG_LEN  first word address; captured on accepted start.
- length  in  LOG_LEN+1  number of words (0..2**LOG_LEN); captured on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last word is accepted downstream.
- bram_en  out  1  to RAM enb; registered.
- bram_addr  out  LOG_LEN  to RAM addrb; registered.
- bram_dout  in  DWIDTH  from RAM dob.
- m_data  out  DWIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready from the consumer.

Behaviour:
- Integration: RAM web is tied to 0 at integration; this block never writes.
- Reset (async, rst=1): state=IDLE; busy=0, done=0, bram_en=0, bram_addr=0, m_valid=0, m_data=0; buffer emptied; counters cleared.
- Reset mid-transfer aborts immediately. No done pulse. Any in-flight read is discarded.
- Reset timing: the read is discarded because the capture flag is cleared.
- RAM timing: bram_en/bram_addr register at posedge k. RAM samples at the following negedge. bram_dout is captured at posedge k+1.
  - Read latency is exactly 1 clk.
  - A 1-bit rd_pending flag tracks the in-flight read.
- States IDLE, RUN, DRAIN (encodings in package).
- IDLE:
  - On start=1 with length>0: capture base_addr and length; issue counter = length, deliver counter = length; busy=1 next cycle; go to RUN.
  - On start=1 with length=0: busy stays 0; done pulses the next cycle; no RAM access.
- RUN: issue a read (bram_en=1, bram_addr=next address) in a cycle only when all of the following hold:
  - issue counter > 0;
  - (buffer count + rd_pending − pop) < 2, where pop = m_valid & m_ready in the same cycle.
- Address handling: the address increments after each issue and wraps modulo 2**LOG_LEN (e.g. base 0xFE, length 4 → FE, FF, 00, 01).
- Issue-done transition: when the issue counter reaches 0, bram_en=0 and the state goes to DRAIN.
- Buffer: 2-entry FIFO.
  - Push when rd_pending is 1 at posedge.
  - m_valid = buffer non-empty; m_data = head entry.
  - Simultaneous push and pop is allowed at any occupancy ≤ 2.
  - The issue rule guarantees push never finds the buffer full.
- Throughput: with m_ready held high, one word per clk after 2-cycle initial latency (start accepted at cycle 0 → first m_valid at cycle 3).
- DRAIN: deliver counter decrements on each pop. When it reaches 0: done=1 for one cycle, busy=0, state returns to IDLE.
- start while busy: ignored, no effect.
- m_data/m_valid stability: both hold stable while m_valid=1 and m_ready=0 (AXI-style rule).
- Arithmetic: counters are LOG_LEN+1 bits; length=2**LOG_LEN reads the whole RAM exactly once.

Decomposition:
- Shared package bram_stream_pkg:
  - state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DRAIN=2'd2);
  - constant BUF_DEPTH=2;
  - default DWIDTH/LOG_LEN for the MLP.
- One sub-module: stream_skid_fifo (2-entry, DWIDTH-wide, push/pop/count, async reset). It is reusable for other RAM readers.

Test Plan:
- Basic: RAM preloaded mem[i]=i+0x100; base=0x10, length=4, m_ready=1 → m_data 0x110, 0x111, 0x112, 0x113 on consecutive cycles, first at cycle 3; done one pulse after the last; busy low afterwards.
- Backpressure: same transfer; m_ready toggles 1,0,0,1,0,1,… → every word delivered exactly once, in order.
  - Check: m_data stable while stalled.
  - Check: bram_en never asserts with 2 words buffered.
- Wrap and full length:
  - base=0xFE, length=4 → addresses FE, FF, 00, 01.
  - length=256 → 256 words, with addresses wrapping back to base.
- Zero length: start with length=0 → no bram_en, done pulses next cycle, busy stays 0.
- start while busy: second start (base=0x40) mid-transfer → ignored; only the first transfer's words appear.
- Reset mid-operation: assert rst asynchronously (between edges) after 2 words → all outputs 0 immediately, no done. A new start afterwards then operates normally.

Source files
------------

// File: rtl/bram_stream_pkg.sv
// ----------------------------------------------------------------------------
// bram_stream_pkg : shared types/constants for the BRAM stream reader
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bram_stream_pkg;
  localparam int DEF_DWIDTH  = 16;
  localparam int DEF_LOG_LEN = 8;
  localparam int BUF_DEPTH   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/stream_skid_fifo.sv
// ----------------------------------------------------------------------------
// stream_skid_fifo : 2-entry FIFO that absorbs a 1-cycle RAM read latency
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module stream_skid_fifo
  import bram_stream_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [DWIDTH-1:0] head_data,
  output logic              valid,
  output logic [1:0]        count
);

  localparam logic [1:0] FULL_CNT = 2'(BUF_DEPTH);
  localparam logic [1:0] CNT_ONE  = 2'd1;

  logic [DWIDTH-1:0] head_q, head_d;
  logic [DWIDTH-1:0] tail_q, tail_d;
  logic [1:0]        count_q, count_d;
  logic              do_pop, do_push;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && ((count_q != FULL_CNT) || do_pop);
    case ({do_push, do_pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = push_data;
        else                 tail_d = push_data;
        count_d = count_q + CNT_ONE;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - CNT_ONE;
      end
      2'b11: begin
        // Occupancy is unchanged; the new word lands behind whatever survives the pop.
        if (count_q == CNT_ONE) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_data = head_q;
  assign valid     = (count_q != 2'd0);
  assign count     = count_q;

endmodule

`default_nettype wire

// File: rtl/bram_stream_reader.sv
// ----------------------------------------------------------------------------
// bram_stream_reader : reads a contiguous RAM block out as a valid/ready stream
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int DWIDTH  = DEF_DWIDTH,
  parameter int LOG_LEN = DEF_LOG_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LOG_LEN-1:0] base_addr,
  input  logic [LOG_LEN:0]   length,
  output logic               busy,
  output logic               done,
  output logic               bram_en,
  output logic [LOG_LEN-1:0] bram_addr,
  input  logic [DWIDTH-1:0]  bram_dout,
  output logic [DWIDTH-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready
);

  localparam logic [LOG_LEN:0]   CNT_ONE  = (LOG_LEN+1)'(1);
  localparam logic [LOG_LEN-1:0] ADDR_ONE = LOG_LEN'(1);

  state_t             state_q, state_d;
  logic [LOG_LEN:0]   issue_cnt_q, issue_cnt_d;
  logic [LOG_LEN:0]   deliver_cnt_q, deliver_cnt_d;
  logic [LOG_LEN-1:0] next_addr_q, next_addr_d;
  logic [LOG_LEN-1:0] bram_addr_q, bram_addr_d;
  logic               bram_en_q, bram_en_d;
  logic               rd_pending_q, rd_pending_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [1:0] buf_count;
  logic       pop;
  logic [2:0] occupancy;
  logic       can_issue;

  assign pop       = m_valid && m_ready;
  // Words buffered or in flight once this cycle's pop has left.
  assign occupancy = {1'b0, buf_count} + {2'b00, rd_pending_q} - {2'b00, pop};
  assign can_issue = (issue_cnt_q != '0) && (occupancy < 3'd2);

  always_comb begin
    state_d       = state_q;
    issue_cnt_d   = issue_cnt_q;
    deliver_cnt_d = deliver_cnt_q;
    next_addr_d   = next_addr_q;
    bram_addr_d   = bram_addr_q;
    bram_en_d     = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;
    if (pop) deliver_cnt_d = deliver_cnt_q - CNT_ONE;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length != '0) begin
            issue_cnt_d   = length;
            deliver_cnt_d = length;
            next_addr_d   = base_addr;
            busy_d        = 1'b1;
            state_d       = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (can_issue) begin
          bram_en_d   = 1'b1;
          bram_addr_d = next_addr_q;
          next_addr_d = next_addr_q + ADDR_ONE;
          issue_cnt_d = issue_cnt_q - CNT_ONE;
          if (issue_cnt_q == CNT_ONE) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && (deliver_cnt_q == CNT_ONE)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rd_pending_d = bram_en_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      issue_cnt_q   <= '0;
      deliver_cnt_q <= '0;
      next_addr_q   <= '0;
      bram_addr_q   <= '0;
      bram_en_q     <= 1'b0;
      rd_pending_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      issue_cnt_q   <= issue_cnt_d;
      deliver_cnt_q <= deliver_cnt_d;
      next_addr_q   <= next_addr_d;
      bram_addr_q   <= bram_addr_d;
      bram_en_q     <= bram_en_d;
      rd_pending_q  <= rd_pending_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  stream_skid_fifo #(
    .DWIDTH(DWIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rd_pending_q),
    .push_data(bram_dout),
    .pop      (pop),
    .head_data(m_data),
    .valid    (m_valid),
    .count    (buf_count)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign bram_en   = bram_en_q;
  assign bram_addr = bram_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
// ----------------------------------------------------------------------------
// tb_bram_stream_reader : scoreboard bench with a negedge-clocked RAM model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bram_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  length = '0;
  logic        busy, done, bram_en, m_valid;
  logic [7:0]  bram_addr;
  logic [15:0] bram_dout = '0;
  logic [15:0] m_data;
  logic        m_ready = 1'b1;

  logic [15:0] mem [256];
  logic [15:0] exp_data_q [$];
  logic [7:0]  exp_addr_q [$];

  int checks = 0;
  int errors = 0;
  int issued = 0;
  int popped = 0;
  int done_cnt = 0;
  int rdy_mode = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  always #5 clk = ~clk;

  bram_stream_reader #(.DWIDTH(16), .LOG_LEN(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .bram_en(bram_en), .bram_addr(bram_addr),
    .bram_dout(bram_dout), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  always @(negedge clk) if (bram_en) bram_dout <= mem[bram_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pops on each handshake and on each RAM read.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_hold", {31'd0, m_valid}, 32'd1);
        check("stall_data_hold", {16'd0, m_data}, {16'd0, prev_data});
      end
      if (bram_en) begin
        check("no_issue_when_buf_full", {31'd0, (issued - popped) <= 1}, 32'd1);
        if (exp_addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read actual_addr=0x%0h required=no_read", bram_addr);
        end else begin
          check("bram_addr", {24'd0, bram_addr}, {24'd0, exp_addr_q.pop_front()});
        end
        issued++;
      end
      if (m_valid && m_ready) begin
        if (exp_data_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word actual=0x%0h required=no_word", m_data);
        end else begin
          check("m_data", {16'd0, m_data}, {16'd0, exp_data_q.pop_front()});
        end
        popped++;
      end
      if (done) done_cnt++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  // Consumer ready: always 1, or the repeating pattern 1,0,0,1,0,1.
  initial begin
    logic [5:0] pat;
    int idx;
    pat = 6'b101001;
    idx = 0;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) m_ready = 1'b1;
      else begin
        m_ready = pat[idx];
        idx = (idx + 1) % 6;
      end
    end
  end

  task automatic push_exp(input logic [7:0] b, input int len);
    logic [7:0] a;
    for (int i = 0; i < len; i++) begin
      a = 8'(int'(b) + i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(mem[a]);
    end
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check({name, "_done_seen"}, {31'd0, done_cnt != d0}, 32'd1);
    check({name, "_busy_low_at_done"}, {31'd0, busy}, 32'd0);
    check({name, "_all_words_out"}, exp_data_q.size(), 32'd0);
    @(negedge clk); #1;
    check({name, "_done_one_pulse"}, {31'd0, done}, 32'd0);
    check({name, "_done_count"}, done_cnt, d0 + 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i + 'h100);

    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_bram_en", {31'd0, bram_en}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", {16'd0, m_data}, 32'd0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // Basic: first word at cycle 3 then one per clock
    rdy_mode = 0;
    push_exp(8'h10, 4);
    do_start(8'h10, 9'd4);
    @(negedge clk); #1;
    check("basic_busy_c1", {31'd0, busy}, 32'd1);
    check("basic_valid_c1", {31'd0, m_valid}, 32'd0);
    @(negedge clk); #1;
    check("basic_valid_c2", {31'd0, m_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      check("basic_valid_stream", {31'd0, m_valid}, 32'd1);
      check("basic_data_stream", {16'd0, m_data}, 32'h110 + k);
    end
    wait_done("basic", 3);

    // Backpressure
    rdy_mode = 1;
    push_exp(8'h20, 5);
    do_start(8'h20, 9'd5);
    wait_done("backpressure", 100);
    rdy_mode = 0;

    // Address wrap
    push_exp(8'hFE, 4);
    do_start(8'hFE, 9'd4);
    wait_done("wrap", 50);

    // Full RAM
    push_exp(8'h30, 256);
    do_start(8'h30, 9'd256);
    wait_done("full_len", 600);

    // Zero length
    d0 = done_cnt;
    do_start(8'h55, 9'd0);
    @(negedge clk); #1;
    check("zero_done_pulse", {31'd0, done}, 32'd1);
    check("zero_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); #1;
    check("zero_done_low", {31'd0, done}, 32'd0);
    check("zero_done_count", done_cnt, d0 + 1);

    // Start while busy is ignored
    rdy_mode = 1;
    push_exp(8'h10, 6);
    do_start(8'h10, 9'd6);
    do_start(8'h40, 9'd4);
    wait_done("start_busy", 100);
    repeat (10) @(negedge clk);
    #1;
    check("start_busy_no_extra", {31'd0, m_valid || busy}, 32'd0);
    rdy_mode = 0;

    // Reset mid-transfer after two delivered words
    push_exp(8'h80, 8);
    d0 = popped;
    do_start(8'h80, 9'd8);
    n = 0;
    while (popped - d0 < 2 && n < 20) begin
      @(negedge clk); #2;
      n++;
    end
    check("rstmid_two_words", popped - d0, 32'd2);
    rst = 1'b1;
    #1;
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_done", {31'd0, done}, 32'd0);
    check("rstmid_bram_en", {31'd0, bram_en}, 32'd0);
    check("rstmid_bram_addr", {24'd0, bram_addr}, 32'd0);
    check("rstmid_m_valid", {31'd0, m_valid}, 32'd0);
    check("rstmid_m_data", {16'd0, m_data}, 32'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
    issued = 0;
    popped = 0;
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("rstmid_no_done", done_cnt, d0);
    push_exp(8'h05, 3);
    do_start(8'h05, 9'd3);
    wait_done("after_reset", 50);

    check("final_addr_q_empty", exp_addr_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
